crop_sequencer: RTL and testbench
=================================

# crop_sequencer

Control block that runs a programmable list of crop windows over repeated passes of a source frame, one crop per pass, on a single shared crop engine (`crop_plus_fifo`). It holds a table of crop origins and drives the engine's origin and clear signals. It gates the frame source, counts handshakes on the engine's input and output sides to detect pass completion, and tags each crop with its index. It sits between the frame source/sink and the crop engine's handshake ports.

## Interface
- PIXEL_BIT_WIDTH, 8, pixel width (used only for engine compatibility checks).
- IN_ROWS, 9, source frame rows.
- IN_COLS, 9, source frame columns.
- OUT_ROWS, 3, crop window rows.
- OUT_COLS, 3, crop window columns.
- NUM_CROPS, 4, origin table depth, ≥1.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin the sequence; accepted only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- cfg_we  in  1  origin table write strobe; honoured only in IDLE.
- cfg_idx  in  IW=max(1,$clog2(NUM_CROPS))  table entry.
- cfg_y  in  $clog2(IN_ROWS)  origin row.
- cfg_x  in  $clog2(IN_COLS)  origin column.
- in_fire  in  1  engine input handshake observed (in_valid & in_ready).
- out_fire  in  1  engine output handshake observed (out_valid & out_ready).
- src_go  out  1  frame source may present pixels.
- eng_clear  out  1  one-cycle synchronous clear pulse to the engine.
- crop_y1, crop_x1  out  as cfg_y/cfg_x  active origin to the engine.
- crop_idx  out  IW  index of the active crop.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last crop completes.

## Operation
- States:
  - IDLE: start → LOAD with idx=0.
  - LOAD: one cycle.
    - crop_y1/crop_x1 ← table[idx].
    - eng_clear=1.
    - Per-pass counters cleared.
    - Next state RUN.
  - RUN: src_go=1.
    - in_cnt increments on in_fire.
    - out_cnt increments on out_fire.
    - On the in_fire that makes in_cnt = IN_ROWS*IN_COLS, src_go drops on the next cycle and the state moves to DRAIN.
  - DRAIN: src_go=0; out_fire is still counted.
    - When out_cnt = OUT_ROWS*OUT_COLS: go to LOAD with idx+1, or to DONE if idx = NUM_CROPS-1.
  - DONE: done=1 for one cycle, then IDLE.
- out_fire counting runs in both RUN and DRAIN, so output completing before input is legal.
- In RUN, if out_cnt is already full when the input completes, DRAIN lasts exactly one cycle.
- Counter saturation:
  - in_fire in DRAIN is a protocol error. It is ignored and in_cnt holds.
  - out_fire beyond OUT_ROWS*OUT_COLS holds out_cnt.
- abort in any state → IDLE the next cycle, no done pulse. The table is preserved.
- start while busy is ignored. Simultaneous start and abort in IDLE: abort wins.
- cfg_we while busy is ignored. The table is not reset by reset_n; its contents are undefined until written.
- Counter width: $clog2(IN_ROWS*IN_COLS+1).

## Timing
- Reset values:
  - state IDLE.
  - src_go=0, eng_clear=0, done=0, busy=0.
  - crop_idx=0, crop_y1=0, crop_x1=0.
- start→eng_clear: LOAD is the cycle after start is sampled; eng_clear is high during that cycle.
- RUN begins 2 cycles after start. Minimum pass length is IN_ROWS*IN_COLS + 2 cycles.
- crop_y1, crop_x1 and crop_idx are registered. They change only on entry to LOAD and are stable through RUN and DRAIN.
- done follows the final out_fire by 2 cycles: DRAIN exit, then the DONE cycle.

## Configuration
- CROP_SEQ_BOUNDS_CHECK_EN defined:
  - In LOAD, an entry with y+OUT_ROWS>IN_ROWS or x+OUT_COLS>IN_COLS is skipped. There is no eng_clear and no RUN; idx advances the next cycle (or the state goes to DONE).
  - A sticky output bounds_err (1 bit, cleared by start) is set.
- Undefined: no check and no bounds_err port. Out-of-range origins are passed to the engine unchanged.

## Structure
- Package crop_pkg holds:
  - State enum crop_seq_state_t.
  - origin_t struct {y, x}.
  - localparams IN_PIX=IN_ROWS*IN_COLS and OUT_PIX=OUT_ROWS*OUT_COLS.
- One sub-module, beat_counter: a saturating up-counter with clear and terminal flag, instantiated twice (input side, output side).

## Test plan
Bench configuration: 9×9 frame, 3×3 window, NUM_CROPS=2, table {(2,2),(5,6)}.
- Full sequence with fire signals every cycle → two eng_clear pulses, crop_idx 0 then 1, src_go high for 81 cycles per pass, a single done pulse, busy low afterwards.
- Randomised in_fire/out_fire → done only after 162 in_fire and 18 out_fire; crop_y1/x1 read (2,2) then (5,6).
- All 9 out_fire before the 81st in_fire → DRAIN lasts 1 cycle, then LOAD for idx 1.
- abort asserted during RUN of crop 0 at in_cnt=40 → IDLE the next cycle, no done pulse; a new start restarts at idx 0.
- cfg_we while busy writes (7,7) to entry 1 → ignored; pass 2 still uses (5,6).
- With CROP_SEQ_BOUNDS_CHECK_EN and entry 1=(7,7) → bounds_err=1, no second eng_clear, done 2 cycles after crop 0 finishes.

Source files
------------

// File: rtl/crop_pkg.sv
// Shared types and default geometry for the crop sequencer.
package crop_pkg;

    localparam int unsigned DEF_IN_ROWS  = 9;
    localparam int unsigned DEF_IN_COLS  = 9;
    localparam int unsigned DEF_OUT_ROWS = 3;
    localparam int unsigned DEF_OUT_COLS = 3;

    localparam int unsigned IN_PIX  = DEF_IN_ROWS * DEF_IN_COLS;
    localparam int unsigned OUT_PIX = DEF_OUT_ROWS * DEF_OUT_COLS;

    // Origin fields are sized for the default frame; the top rejects wider geometries.
    localparam int unsigned Y_W = $clog2(DEF_IN_ROWS);
    localparam int unsigned X_W = $clog2(DEF_IN_COLS);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain,
        StDone
    } crop_seq_state_t;

    typedef struct packed {
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
    } origin_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Saturating handshake counter with synchronous clear, full flag and a
// flag for the beat that makes it full.
module beat_counter #(
    parameter int unsigned Width = 7,
    parameter int unsigned Limit = 81
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic full_o,
    output logic last_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    assign full_o = (cnt_q == Width'(Limit));
    assign last_o = inc_i && !full_o && (cnt_q == Width'(Limit - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !full_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/crop_sequencer.sv
// Runs a table of crop origins over repeated source-frame passes on one crop engine.
// Optional CROP_SEQ_BOUNDS_CHECK_EN skips out-of-frame origins and flags bounds_err.
module crop_sequencer
    import crop_pkg::*;
#(
    parameter int unsigned PIXEL_BIT_WIDTH = 8,
    parameter int unsigned IN_ROWS         = DEF_IN_ROWS,
    parameter int unsigned IN_COLS         = DEF_IN_COLS,
    parameter int unsigned OUT_ROWS        = DEF_OUT_ROWS,
    parameter int unsigned OUT_COLS        = DEF_OUT_COLS,
    parameter int unsigned NUM_CROPS       = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               cfg_we,
    input  logic [idx_width(NUM_CROPS)-1:0]    cfg_idx,
    input  logic [$clog2(IN_ROWS)-1:0]         cfg_y,
    input  logic [$clog2(IN_COLS)-1:0]         cfg_x,
    input  logic                               in_fire,
    input  logic                               out_fire,
    output logic                               src_go,
    output logic                               eng_clear,
    output logic [$clog2(IN_ROWS)-1:0]         crop_y1,
    output logic [$clog2(IN_COLS)-1:0]         crop_x1,
    output logic [idx_width(NUM_CROPS)-1:0]    crop_idx,
    output logic                               busy,
    output logic                               done
`ifdef CROP_SEQ_BOUNDS_CHECK_EN
    ,
    output logic                               bounds_err
`endif
);

    localparam int unsigned IW     = idx_width(NUM_CROPS);
    localparam int unsigned YW     = $clog2(IN_ROWS);
    localparam int unsigned XW     = $clog2(IN_COLS);
    localparam int unsigned InPix  = IN_ROWS * IN_COLS;
    localparam int unsigned OutPix = OUT_ROWS * OUT_COLS;
    localparam int unsigned CntW   = $clog2(InPix + 1);

    if (PIXEL_BIT_WIDTH == 0 || NUM_CROPS == 0 || YW > Y_W || XW > X_W ||
        OUT_ROWS > IN_ROWS || OUT_COLS > IN_COLS) begin : g_bad_cfg
        $error("crop_sequencer: unsupported parameter set");
    end

    crop_seq_state_t state_d, state_q;
    logic [IW-1:0]   crop_idx_d, crop_idx_q, idx_nxt;
    logic [YW-1:0]   crop_y1_d, crop_y1_q;
    logic [XW-1:0]   crop_x1_d, crop_x1_q;
    origin_t         tbl_q [NUM_CROPS];
    logic            tbl_we, is_last, advance;
    logic            in_full, in_last, out_full, out_last;
    logic            unused_flags;

    assign idx_nxt      = crop_idx_q + 1'b1;
    assign is_last      = (crop_idx_q == IW'(NUM_CROPS - 1));
    assign unused_flags = in_full | out_last;

    beat_counter #(
        .Width(CntW),
        .Limit(InPix)
    ) u_in_cnt (
        .clk_i (clk),
        .rst_ni(reset_n),
        .clr_i (state_q == StLoad),
        .inc_i (in_fire && state_q == StRun),
        .full_o(in_full),
        .last_o(in_last)
    );

    // Output beats may complete before the input side, so count them in RUN too.
    beat_counter #(
        .Width(CntW),
        .Limit(OutPix)
    ) u_out_cnt (
        .clk_i (clk),
        .rst_ni(reset_n),
        .clr_i (state_q == StLoad),
        .inc_i (out_fire && (state_q == StRun || state_q == StDrain)),
        .full_o(out_full),
        .last_o(out_last)
    );

`ifdef CROP_SEQ_BOUNDS_CHECK_EN
    logic oob, bounds_err_d, bounds_err_q;

    assign oob = ((32'(crop_y1_q) + OUT_ROWS) > IN_ROWS) ||
                 ((32'(crop_x1_q) + OUT_COLS) > IN_COLS);
    assign bounds_err = bounds_err_q;

    always_comb begin
        bounds_err_d = bounds_err_q;
        if (state_q == StIdle && start && !abort) begin
            bounds_err_d = 1'b0;
        end else if (state_q == StLoad && oob) begin
            bounds_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bounds_err_q <= 1'b0;
        end else begin
            bounds_err_q <= bounds_err_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        crop_idx_d = crop_idx_q;
        crop_y1_d  = crop_y1_q;
        crop_x1_d  = crop_x1_q;
        advance    = 1'b0;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d    = StLoad;
                        crop_idx_d = '0;
                        crop_y1_d  = YW'(tbl_q[0].y);
                        crop_x1_d  = XW'(tbl_q[0].x);
                    end
                end
                StLoad: begin
`ifdef CROP_SEQ_BOUNDS_CHECK_EN
                    if (oob) advance = 1'b1;
                    else     state_d = StRun;
`else
                    state_d = StRun;
`endif
                end
                StRun:   if (in_last) state_d = StDrain;
                StDrain: if (out_full) advance = 1'b1;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
            if (advance) begin
                if (is_last) begin
                    state_d = StDone;
                end else begin
                    state_d    = StLoad;
                    crop_idx_d = idx_nxt;
                    crop_y1_d  = YW'(tbl_q[idx_nxt].y);
                    crop_x1_d  = XW'(tbl_q[idx_nxt].x);
                end
            end
        end
    end

    always_comb begin
        src_go    = (state_q == StRun);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        eng_clear = (state_q == StLoad);
`ifdef CROP_SEQ_BOUNDS_CHECK_EN
        eng_clear = eng_clear && !oob;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            crop_idx_q <= '0;
            crop_y1_q  <= '0;
            crop_x1_q  <= '0;
        end else begin
            state_q    <= state_d;
            crop_idx_q <= crop_idx_d;
            crop_y1_q  <= crop_y1_d;
            crop_x1_q  <= crop_x1_d;
        end
    end

    // Origin table has no reset; it is only meaningful once written.
    assign tbl_we = cfg_we && (state_q == StIdle) && (32'(cfg_idx) < NUM_CROPS);

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_q[cfg_idx] <= origin_t'{y: Y_W'(cfg_y), x: X_W'(cfg_x)};
        end
    end

    assign crop_idx = crop_idx_q;
    assign crop_y1  = crop_y1_q;
    assign crop_x1  = crop_x1_q;

endmodule

// File: tb/tb_crop_sequencer.sv
// Bench for crop_sequencer: 9x9 frame, 3x3 window, two crops {(2,2),(5,6)}.
module tb_crop_sequencer;
    import crop_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n, start, abort, cfg_we;
    logic [0:0] cfg_idx;
    logic [3:0] cfg_y, cfg_x;
    logic       in_fire = 1'b0;
    logic       out_fire = 1'b0;
    logic       src_go, eng_clear, busy, done;
    logic [3:0] crop_y1, crop_x1;
    logic [0:0] crop_idx;
`ifdef CROP_SEQ_BOUNDS_CHECK_EN
    logic       bounds_err;
`endif

    crop_sequencer #(
        .PIXEL_BIT_WIDTH(8),
        .IN_ROWS        (9),
        .IN_COLS        (9),
        .OUT_ROWS       (3),
        .OUT_COLS       (3),
        .NUM_CROPS      (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_y    (cfg_y),
        .cfg_x    (cfg_x),
        .in_fire  (in_fire),
        .out_fire (out_fire),
        .src_go   (src_go),
        .eng_clear(eng_clear),
        .crop_y1  (crop_y1),
        .crop_x1  (crop_x1),
        .crop_idx (crop_idx),
        .busy     (busy),
        .done     (done)
`ifdef CROP_SEQ_BOUNDS_CHECK_EN
        ,
        .bounds_err(bounds_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int idx; int y; int x;} crop_exp_t;
    typedef struct {
        int in_pct; int out_pct; int exp_clears; int exp_in; int exp_out;
        int exp_srcgo; int exp_gap;
    } vec_t;

    crop_exp_t sb[$];
    int n_checks = 0, n_fail = 0;
    int n_clear = 0, n_done = 0, in_pass = 0, in_total = 0, out_total = 0, out_left = 0;
    int srcgo_cycles = 0, gap = 0, gap_max = 0;
    bit fire_en = 1'b0;
    int in_pct = 100, out_pct = 100;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Engine/source model and scoreboard: observe at negedge, drive fires for the next edge.
    always @(negedge clk) begin : mon
        crop_exp_t e;
        if (reset_n) begin
            if (start && !busy) begin
                gap_max = 0;
                gap     = 0;
            end
            if (eng_clear) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: eng_clear with crop_idx=%0d, no crop expected",
                             crop_idx);
                end else begin
                    e = sb.pop_front();
                    chk("clr_idx", int'(crop_idx), e.idx);
                    chk("clr_y1", int'(crop_y1), e.y);
                    chk("clr_x1", int'(crop_x1), e.x);
                end
                n_clear++;
                in_pass  = 0;
                out_left = OUT_PIX;
            end
            if (done) n_done++;
            if (eng_clear || done) begin
                if (gap > gap_max) gap_max = gap;
                gap = 0;
            end
            if (src_go) srcgo_cycles++;
            if (busy && !src_go && !eng_clear && !done) gap++;
            in_fire  = fire_en && src_go && (int'($urandom_range(99)) < in_pct);
            out_fire = fire_en && (out_left > 0) && (src_go || (busy && !eng_clear && !done))
                       && (int'($urandom_range(99)) < out_pct);
            if (in_fire) begin
                in_pass++;
                in_total++;
            end
            if (out_fire) begin
                out_left--;
                out_total++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input int idx, input int y, input int x);
        cfg_we  = 1'b1;
        cfg_idx = 1'(idx);
        cfg_y   = 4'(y);
        cfg_x   = 4'(x);
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int budget);
        int k = 0;
        while (n_done == d0 && k < budget) begin
            tick();
            k++;
        end
        if (n_done == d0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected a done pulse", name, k);
        end
    endtask

    task automatic push_both();
        sb.push_back('{0, 2, 2});
        sb.push_back('{1, 5, 6});
    endtask

    initial begin : wdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vec[4];
        int c0, d0, i0, o0, s0, k;

        vec[0] = '{100, 100, 2, 162, 18, 162, 1};
        vec[1] = '{60, 40, 2, 162, 18, -1, -1};
        vec[2] = '{30, 100, 2, 162, 18, -1, 1};
        vec[3] = '{100, 5, 2, 162, 18, 162, -1};

        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        cfg_we  = 1'b0;
        cfg_idx = '0;
        cfg_y   = '0;
        cfg_x   = '0;
        repeat (3) tick();
        chk("rst_src_go", int'(src_go), 0);
        chk("rst_eng_clear", int'(eng_clear), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_crop_idx", int'(crop_idx), 0);
        chk("rst_crop_y1", int'(crop_y1), 0);
        chk("rst_crop_x1", int'(crop_x1), 0);
        reset_n = 1'b1;
        tick();
        write_cfg(0, 2, 2);
        write_cfg(1, 5, 6);

        for (int i = 0; i < 4; i++) begin
            c0 = n_clear; d0 = n_done; i0 = in_total; o0 = out_total; s0 = srcgo_cycles;
            in_pct  = vec[i].in_pct;
            out_pct = vec[i].out_pct;
            fire_en = 1'b1;
            push_both();
            pulse_start();
            wait_done($sformatf("v%0d", i), d0, 4000);
            repeat (3) tick();
            chk($sformatf("v%0d_done_pulses", i), n_done - d0, 1);
            chk($sformatf("v%0d_clears", i), n_clear - c0, vec[i].exp_clears);
            chk($sformatf("v%0d_in_fires", i), in_total - i0, vec[i].exp_in);
            chk($sformatf("v%0d_out_fires", i), out_total - o0, vec[i].exp_out);
            if (vec[i].exp_srcgo >= 0)
                chk($sformatf("v%0d_src_go_cycles", i), srcgo_cycles - s0, vec[i].exp_srcgo);
            if (vec[i].exp_gap >= 0)
                chk($sformatf("v%0d_drain_len", i), gap_max, vec[i].exp_gap);
            chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
            chk($sformatf("v%0d_sb_empty", i), sb.size(), 0);
        end

        // Abort in RUN of crop 0 once 40 input beats have been counted.
        c0 = n_clear; d0 = n_done;
        in_pct = 100; out_pct = 0; fire_en = 1'b1;
        sb.push_back('{0, 2, 2});
        pulse_start();
        k = 0;
        while (!(n_clear > c0 && in_pass >= 40) && k < 500) begin
            tick();
            k++;
        end
        chk("abort_in_run", int'(src_go), 1);
        abort = 1'b1;
        fire_en = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_src_go", int'(src_go), 0);
        repeat (5) tick();
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_sb_empty", sb.size(), 0);

        // Start and abort together in IDLE: abort wins.
        c0 = n_clear;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        repeat (3) tick();
        chk("start_abort_clears", n_clear - c0, 0);

        // Restart after abort begins again at crop 0.
        c0 = n_clear; d0 = n_done;
        in_pct = 100; out_pct = 100; fire_en = 1'b1;
        push_both();
        pulse_start();
        wait_done("restart", d0, 2000);
        repeat (2) tick();
        chk("restart_clears", n_clear - c0, 2);
        chk("restart_done", n_done - d0, 1);

        // cfg_we and start while busy are both ignored.
        c0 = n_clear; d0 = n_done;
        push_both();
        pulse_start();
        k = 0;
        while (n_clear == c0 && k < 50) begin
            tick();
            k++;
        end
        repeat (5) tick();
        write_cfg(1, 7, 7);
        pulse_start();
        wait_done("cfg_busy", d0, 2000);
        repeat (3) tick();
        chk("cfg_busy_clears", n_clear - c0, 2);
        chk("cfg_busy_done", n_done - d0, 1);
        chk("cfg_busy_idle", int'(busy), 0);

`ifdef CROP_SEQ_BOUNDS_CHECK_EN
        write_cfg(1, 7, 7);
        c0 = n_clear; d0 = n_done;
        sb.push_back('{0, 2, 2});
        pulse_start();
        wait_done("bounds", d0, 2000);
        repeat (2) tick();
        chk("bounds_err_set", int'(bounds_err), 1);
        chk("bounds_clears", n_clear - c0, 1);
        chk("bounds_done_gap", gap_max, 2);
        chk("bounds_done", n_done - d0, 1);
        write_cfg(1, 5, 6);
        c0 = n_clear; d0 = n_done;
        push_both();
        pulse_start();
        wait_done("bounds_ok", d0, 2000);
        repeat (2) tick();
        chk("bounds_err_clr", int'(bounds_err), 0);
        chk("bounds_ok_clears", n_clear - c0, 2);
`endif

        fire_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
